// File: rtl/hilo_mdu.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle, sign fix-up at the end.
module hilo_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic        op_mfhi,
    input  logic        op_mflo,
    input  logic        cancel,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [4:0]  count_q,   count_d;
    logic        is_div_q,  is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_q,     dbz_d;
    logic [31:0] opnd_q,    opnd_d;
    logic [32:0] acc_q,     acc_d;
    logic [31:0] sh_q,      sh_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;

    logic        start_any;
    logic        start_div;
    logic        start_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] prod_mag;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Priority div > divu > mult > multu resolves any non-one-hot strobe combination.
    assign start_div    = op_div | op_divu;
    assign start_any    = start_div | op_mult | op_multu;
    assign start_signed = op_div | (~op_divu & op_mult);

    assign mag_a = (start_signed && srca[31]) ? (~srca + 32'd1) : srca;
    assign mag_b = (start_signed && srcb[31]) ? (~srcb + 32'd1) : srcb;

    // Multiply: acc holds the running high half, sh the multiplier shifting out as product bits shift in.
    assign mul_sum = {1'b0, acc_q[31:0]} + (sh_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Divide: acc is the 33-bit partial remainder, sh the dividend shifting out as quotient bits shift in.
    assign div_shift = {acc_q[31:0], sh_q[31]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod_mag = {acc_q[31:0], sh_q};
    assign prod_fix = neg_res_q ? (~prod_mag + 64'd1) : prod_mag;
    assign quot_fix = neg_res_q ? (~sh_q + 32'd1) : sh_q;
    assign rem_fix  = neg_rem_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (!cancel) begin
                    if (start_any) begin
                        state_d   = ST_CALC;
                        count_d   = 5'd31;
                        is_div_d  = start_div;
                        neg_res_d = start_signed & (srca[31] ^ srcb[31]);
                        neg_rem_d = start_signed & srca[31];
                        dbz_d     = start_div & (srcb == 32'd0);
                        opnd_d    = start_div ? mag_b : mag_a;
                        sh_d      = start_div ? mag_a : mag_b;
                        acc_d     = 33'd0;
                    end else if (op_mthi) begin
                        hi_d = srca;
                    end else if (op_mtlo) begin
                        lo_d = srca;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    count_d = 5'd0;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[32]) begin
                            acc_d = div_diff;
                            sh_d  = {sh_q[30:0], 1'b1};
                        end else begin
                            acc_d = div_shift;
                            sh_d  = {sh_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_d = {1'b0, mul_sum[32:1]};
                        sh_d  = {mul_sum[0], sh_q[31:1]};
                    end
                    if (count_q == 5'd0) begin
                        state_d = ST_FIX;
                    end else begin
                        count_d = count_q - 5'd1;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = dbz_q ? 32'hFFFF_FFFF : quot_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 33'd0;
            sh_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != ST_IDLE);
    assign stall = busy & (op_mult | op_multu | op_div | op_divu |
                           op_mthi | op_mtlo | op_mfhi | op_mflo);

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Iterative multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage directly downstream of the control unit. It consumes the decoded one-hot `op_mult`, `op_multu`, `op_div`, `op_divu`, `op_mthi`, `op_mtlo`, `op_mfhi` and `op_mflo` strobes together with the EX-stage operands. It runs a 32-iteration radix-2 shift-add or shift-subtract sequence and writes HI/LO on completion. It raises a stall toward the hazard logic while any HI/LO consumer or producer meets a busy unit.

## Interface
- none: the datapath is fixed at 32 bits.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `op_mult`, `op_multu`, `op_div`, `op_divu`  in  1 each  start strobes, sampled when the unit is idle.
- `op_mthi`, `op_mtlo`  in  1 each  direct writes of HI or LO from `srca`.
- `op_mfhi`, `op_mflo`  in  1 each  HI/LO read requests, used only for stall generation.
- `cancel`  in  1  exception/flush; aborts the current op and suppresses a same-cycle start.
- `srca`  in  32  rs operand (multiplicand or dividend).
- `srcb`  in  32  rt operand (multiplier or divisor).
- `hi`, `lo`  out  32 each  architectural HI/LO, registered.
- `busy`  out  1  equals (state != IDLE).
- `stall`  out  1  = `busy` & (any of the eight op strobes); combinational.

## Operation
- The op strobes are one-hot by construction. If several are asserted together, precedence is div > divu > mult > multu > mthi > mtlo.
- The FSM has three states.
  - IDLE: on a start strobe with `cancel`=0, latch the operand magnitudes and the signed/op type, clear the accumulator, load count=31, and go to CALC.
  - CALC: perform one iteration per cycle. At count==0 go to FIX; otherwise decrement count.
  - FIX: apply sign correction, write HI/LO, and go to IDLE.
- Signed ops (mult, div) operate on absolute values.
  - Product sign = sign(a) xor sign(b).
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
  - Negation is two's complement on 64 bits (product) or 32 bits (quotient/remainder).
- mult/multu: {HI,LO} = 64-bit product.
- div/divu: LO = quotient, HI = remainder. A restoring divider uses a 33-bit partial remainder.
- Divide by zero (`srcb`=0 at start): the op still runs its full latency. Result is HI = original `srca` and LO = 0xFFFFFFFF, for both signed and unsigned.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, which falls out of the magnitude algorithm.
- mthi/mtlo in IDLE: HI (or LO) <= `srca` at the next edge; single cycle; `busy` stays 0.
- Any strobe while `busy`=1 is ignored. `stall` is asserted so the upstream pipeline holds the instruction and re-presents it later.
- `cancel` in CALC or FIX: return to IDLE at the next edge. HI/LO are not written; FIX with `cancel` suppresses the write.

## Timing
- Reset: `hi`=0, `lo`=0, state IDLE, count=0, `busy`=0. `stall` follows the inputs and is 0 while idle.
- A start sampled at the edge ending cycle T gives:
  - CALC in cycles T+1..T+32;
  - FIX in cycle T+33;
  - new HI/LO visible in cycle T+34.
- `busy` is 1 in cycles T+1..T+33 and 0 in T+34. A back-to-back start may be sampled in T+34.
- An `op_mfhi` or `op_mflo` presented in T+34 reads the new value, with no extra forwarding inside the block.
- `rst` asserted mid-operation clears everything immediately (asynchronously); no HI/LO write occurs.
- `cancel` sampled in cycle T+k (1≤k≤33) gives `busy`=0 in T+k+1.
- mthi/mtlo latency is one edge. No stall is generated for them when idle.

## Test plan
- Reset: drive `rst` high mid-run, then release. Required: `hi`=`lo`=0 and `busy`=0 immediately. Then mthi with `srca`=0xDEADBEEF gives `hi`=0xDEADBEEF one edge later and `lo` stays 0.
- Multiply with `srca`=0xFFFFFFFD, `srcb`=5:
  - mult gives HI=0xFFFFFFFF, LO=0xFFFFFFF1 in cycle T+34;
  - multu gives HI=0x00000004, LO=0xFFFFFFF1.
  - `busy` must be high for exactly 33 cycles in each case.
- Divide:
  - div 0xFFFFFFF9 / 2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - divu 7 / 2 gives LO=3, HI=1;
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: div `srca`=0x12345678, `srcb`=0 gives HI=0x12345678, LO=0xFFFFFFFF at T+34.
- Stall and ignore while busy:
  - start mult; assert `op_mflo` from T+5 onward. Required: `stall`=1 in T+5..T+33 and `stall`=0 in T+34.
  - `op_mthi` with `srca`=0x55 at T+10 is ignored, and the mult result is intact.
- Cancel:
  - start divu, assert `cancel` at T+10. Required: `busy`=0 at T+11 and HI/LO unchanged from their prior values.
  - `cancel` in the same cycle as `op_div`: no start occurs and `busy` stays 0.
